// File: rtl/pos_sweep_pkg.sv
// pos_sweep_pkg
// Shared definitions for the product-of-sums self-test sequencer: the
// controller state type, the number of input vectors of the checked block
// and the truth table the checked block is supposed to produce.
// No ports (package).

package pos_sweep_pkg;

  // Controller phases: waiting for a request, holding a vector while the
  // checked block settles, capturing its output, reporting the result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } SweepState_e;

  localparam int NUM_VEC = 16;

  // Bit i is the output of the checked block for input vector i (abcd, a = MSB).
  // The block is high for vectors 2, 4, 7, 11 and 12.
  localparam logic [NUM_VEC-1:0] POS_EXPECTED = 16'h1894;

endpackage

// File: rtl/pos_sweep_ctrl_if.sv
// pos_sweep_ctrl_if
// Control/result bundle between the test logic and the sweep controller.
//   start    : request a sweep (test logic -> controller)
//   abort    : cancel a sweep in progress (test logic -> controller)
//   busy     : sweep in progress
//   done     : one-cycle pulse when a sweep completes
//   pass     : captured signature matched the expected truth table
//   sig      : captured truth table, bit i = output for vector i
//   fail_idx : lowest mismatching vector, 0 when passing
//   fail_cnt : number of mismatching vectors, 0..16
// Modports: master = test/control logic, slave = sweep controller.

interface pos_sweep_ctrl_if;
  import pos_sweep_pkg::*;

  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               pass;
  logic [NUM_VEC-1:0] sig;
  logic [3:0]         fail_idx;
  logic [4:0]         fail_cnt;

  modport master (
    output start, abort,
    input  busy, done, pass, sig, fail_idx, fail_cnt
  );

  modport slave (
    input  start, abort,
    output busy, done, pass, sig, fail_idx, fail_cnt
  );

endinterface

// File: rtl/pos_sweep_ctrl.sv
// pos_sweep_ctrl
// Exhaustive self-test sequencer for a 4-input combinational block.
// On request it walks vec_o through 0..15, holds each vector for SETTLE
// cycles, samples r_i once per vector into a 16-bit signature and compares
// it bit by bit against EXPECTED, reporting pass, first failing vector and
// mismatch count.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   ctrl  : control/result bundle (slave side of pos_sweep_ctrl_if)
//   r_i   : output of the checked block
//   vec_o : {a,b,c,d} driven onto the checked block
// Parameters:
//   SETTLE   : hold cycles before sampling (0..15; 0 samples the cycle after drive)
//   EXPECTED : expected truth table, bit i = output for vector i

module pos_sweep_ctrl
  import pos_sweep_pkg::*;
#(
  parameter int unsigned        SETTLE   = 1,
  parameter logic [NUM_VEC-1:0] EXPECTED = POS_EXPECTED
) (
  input  logic            clk,
  input  logic            rst,
  pos_sweep_ctrl_if.slave ctrl,
  input  logic            r_i,
  output logic [3:0]      vec_o
);

  localparam logic [3:0] LAST_WAIT = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
  localparam logic [3:0] LAST_VEC  = 4'(NUM_VEC - 1);

  // With no settle time there is nothing to wait for, so every new vector
  // goes straight to its sample cycle.
  localparam SweepState_e VEC_ENTRY = (SETTLE == 0) ? SAMPLE : DRIVE;

  SweepState_e        r_state;
  SweepState_e        w_nextState;
  logic [3:0]         r_idx;
  logic [3:0]         r_waitCnt;
  logic [NUM_VEC-1:0] r_sig;
  logic [3:0]         r_failIdx;
  logic [4:0]         r_failCnt;
  logic               r_pass;

  logic               w_accept;
  logic               w_abort;
  logic               w_sample;
  logic               w_busy;
  logic               w_done;
  logic               w_mismatch;
  logic [4:0]         w_failCntNext;

  // The count including the vector being sampled right now; the final pass
  // verdict must already see a mismatch on vector 15.
  assign w_mismatch    = (r_i != EXPECTED[r_idx]);
  assign w_failCntNext = r_failCnt + {4'd0, w_mismatch};

  // State register: reset drops straight back to IDLE from anywhere,
  // which also guarantees no done pulse for an interrupted sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control decode. Abort is checked before the sample
  // decision so a cancelled sweep never captures another bit. Start is only
  // looked at in IDLE, so a request during DONE or a running sweep is dropped.
  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    w_abort     = 1'b0;
    w_sample    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ctrl.start) begin
          w_accept    = 1'b1;
          w_nextState = VEC_ENTRY;
        end
      end
      DRIVE: begin
        w_busy = 1'b1;
        if (ctrl.abort) begin
          w_abort     = 1'b1;
          w_nextState = IDLE;
        end else if (r_waitCnt == LAST_WAIT) begin
          w_nextState = SAMPLE;
        end
      end
      SAMPLE: begin
        w_busy = 1'b1;
        if (ctrl.abort) begin
          w_abort     = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_sample    = 1'b1;
          w_nextState = (r_idx == LAST_VEC) ? DONE : VEC_ENTRY;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: vector index, settle counter and the result registers.
  // Results are only cleared by an accepted start, so they stay readable
  // after done (or after an abort, minus the verdict) until the next sweep.
  // The final vector leaves vec_o at 15 rather than wrapping to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= 4'd0;
      r_waitCnt <= 4'd0;
      vec_o     <= 4'd0;
      r_sig     <= '0;
      r_failIdx <= 4'd0;
      r_failCnt <= 5'd0;
      r_pass    <= 1'b0;
    end else if (w_accept) begin
      r_idx     <= 4'd0;
      r_waitCnt <= 4'd0;
      vec_o     <= 4'd0;
      r_sig     <= '0;
      r_failIdx <= 4'd0;
      r_failCnt <= 5'd0;
      r_pass    <= 1'b0;
    end else if (w_abort) begin
      r_idx     <= 4'd0;
      r_waitCnt <= 4'd0;
      vec_o     <= 4'd0;
      r_pass    <= 1'b0;
    end else if (w_sample) begin
      r_sig[r_idx] <= r_i;
      r_failCnt    <= w_failCntNext;
      if (w_mismatch && (r_failCnt == 5'd0)) begin
        r_failIdx <= r_idx;
      end
      r_waitCnt <= 4'd0;
      if (r_idx == LAST_VEC) begin
        r_pass <= (w_failCntNext == 5'd0);
      end else begin
        r_idx <= r_idx + 4'd1;
        vec_o <= r_idx + 4'd1;
      end
    end else if (r_state == DRIVE) begin
      r_waitCnt <= r_waitCnt + 4'd1;
    end
  end

  assign ctrl.busy     = w_busy;
  assign ctrl.done     = w_done;
  assign ctrl.pass     = r_pass;
  assign ctrl.sig      = r_sig;
  assign ctrl.fail_idx = r_failIdx;
  assign ctrl.fail_cnt = r_failCnt;

endmodule

// File: tb/tb_pos_sweep_ctrl.sv
// tb_pos_sweep_ctrl
// Three sweep controllers (SETTLE = 1, 3, 0) share start/abort/reset and are
// each fed by a harness source that is either the correct product-of-sums
// block, a constant 0, a constant 1 or a random truth table.

module tb_pos_sweep_ctrl;

  localparam logic [15:0] TB_EXPECTED = 16'h1894;
  localparam int          NUM_DUT     = 3;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [1:0]  mode    = 2'd0;
  logic [15:0] tbl     = 16'h0000;
  logic        checkEn = 1'b0;

  int vectors     = 0;
  int miscompares = 0;
  int setA[NUM_DUT] = '{1, 3, 0};

  pos_sweep_ctrl_if ifA ();
  pos_sweep_ctrl_if ifB ();
  pos_sweep_ctrl_if ifC ();

  logic [3:0]  vecA [NUM_DUT];
  logic        rA   [NUM_DUT];
  logic        busyA[NUM_DUT];
  logic        doneA[NUM_DUT];
  logic        passA[NUM_DUT];
  logic [15:0] sigA [NUM_DUT];
  logic [3:0]  fIdxA[NUM_DUT];
  logic [4:0]  fCntA[NUM_DUT];

  // The checked product-of-sums block: high for abcd = 2, 4, 7, 11, 12.
  function automatic logic posBlock(input logic [3:0] v);
    return (v == 4'd2) || (v == 4'd4) || (v == 4'd7) || (v == 4'd11) || (v == 4'd12);
  endfunction

  // Harness source feeding r_i: 0 = correct block, 1 = tied 0, 2 = tied 1, 3 = table.
  function automatic logic srcBit(input logic [1:0] m, input logic [15:0] t, input logic [3:0] v);
    case (m)
      2'd0:    return posBlock(v);
      2'd1:    return 1'b0;
      2'd2:    return 1'b1;
      default: return t[v];
    endcase
  endfunction

  assign ifA.start = start;
  assign ifA.abort = abort;
  assign ifB.start = start;
  assign ifB.abort = abort;
  assign ifC.start = start;
  assign ifC.abort = abort;

  assign rA[0] = srcBit(mode, tbl, vecA[0]);
  assign rA[1] = srcBit(mode, tbl, vecA[1]);
  assign rA[2] = srcBit(mode, tbl, vecA[2]);

  assign busyA[0] = ifA.busy;
  assign busyA[1] = ifB.busy;
  assign busyA[2] = ifC.busy;
  assign doneA[0] = ifA.done;
  assign doneA[1] = ifB.done;
  assign doneA[2] = ifC.done;
  assign passA[0] = ifA.pass;
  assign passA[1] = ifB.pass;
  assign passA[2] = ifC.pass;
  assign sigA[0]  = ifA.sig;
  assign sigA[1]  = ifB.sig;
  assign sigA[2]  = ifC.sig;
  assign fIdxA[0] = ifA.fail_idx;
  assign fIdxA[1] = ifB.fail_idx;
  assign fIdxA[2] = ifC.fail_idx;
  assign fCntA[0] = ifA.fail_cnt;
  assign fCntA[1] = ifB.fail_cnt;
  assign fCntA[2] = ifC.fail_cnt;

  pos_sweep_ctrl #(.SETTLE(1)) uDutS1 (
    .clk(clk), .rst(rst), .ctrl(ifA), .r_i(rA[0]), .vec_o(vecA[0])
  );

  pos_sweep_ctrl #(.SETTLE(3)) uDutS3 (
    .clk(clk), .rst(rst), .ctrl(ifB), .r_i(rA[1]), .vec_o(vecA[1])
  );

  pos_sweep_ctrl #(.SETTLE(0)) uDutS0 (
    .clk(clk), .rst(rst), .ctrl(ifC), .r_i(rA[2]), .vec_o(vecA[2])
  );

  always #5 clk = ~clk;

  // Reference model: a sweep is a count of elapsed cycles k since the
  // accepting edge. Vector k/(S+1) is on the bus, and the last cycle of
  // each (S+1)-cycle slot is the sample point. Results are derived from the
  // set of sampled bits rather than tracked incrementally.
  bit          mRun    [NUM_DUT];
  bit          mDone   [NUM_DUT];
  int          mK      [NUM_DUT];
  logic [3:0]  mVecHeld[NUM_DUT];
  logic [15:0] mSig    [NUM_DUT];
  logic [15:0] mMask   [NUM_DUT];
  logic        mPass   [NUM_DUT];
  int          modelV;

  function automatic logic [4:0] expCnt(input logic [15:0] s, input logic [15:0] m);
    return 5'($countones((s ^ TB_EXPECTED) & m));
  endfunction

  function automatic logic [3:0] expIdx(input logic [15:0] s, input logic [15:0] m);
    logic [15:0] d;
    logic [3:0]  idx;
    d   = (s ^ TB_EXPECTED) & m;
    idx = 4'd0;
    for (int b = 15; b >= 0; b--) begin
      if (d[b]) idx = 4'(b);
    end
    return idx;
  endfunction

  function automatic logic [3:0] expVec(input bit run, input int k, input int s, input logic [3:0] held);
    return run ? 4'(k / (s + 1)) : held;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DUT; i++) begin
        mRun[i]     = 1'b0;
        mDone[i]    = 1'b0;
        mK[i]       = 0;
        mVecHeld[i] = 4'd0;
        mSig[i]     = 16'h0000;
        mMask[i]    = 16'h0000;
        mPass[i]    = 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_DUT; i++) begin
        if (mRun[i]) begin
          if (abort) begin
            mRun[i]     = 1'b0;
            mVecHeld[i] = 4'd0;
            mPass[i]    = 1'b0;
          end else begin
            modelV = mK[i] / (setA[i] + 1);
            if ((mK[i] % (setA[i] + 1)) == setA[i]) begin
              mSig[i][modelV]  = srcBit(mode, tbl, 4'(modelV));
              mMask[i][modelV] = 1'b1;
            end
            mK[i]++;
            if (mK[i] == 16 * (setA[i] + 1)) begin
              mRun[i]     = 1'b0;
              mDone[i]    = 1'b1;
              mVecHeld[i] = 4'd15;
              mPass[i]    = (expCnt(mSig[i], mMask[i]) == 5'd0);
            end
          end
        end else if (mDone[i]) begin
          mDone[i] = 1'b0;
        end else if (start) begin
          mRun[i]     = 1'b1;
          mK[i]       = 0;
          mSig[i]     = 16'h0000;
          mMask[i]    = 16'h0000;
          mPass[i]    = 1'b0;
          mVecHeld[i] = 4'd0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (dut %0d) at %0t: got %0h, want %0h", name, inst, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  // Per-cycle comparison of every output of every controller against the
  // model, plus bookkeeping of busy run lengths and done pulses.
  int busyRun [NUM_DUT] = '{0, 0, 0};
  int lastBusy[NUM_DUT] = '{0, 0, 0};
  int doneCnt [NUM_DUT] = '{0, 0, 0};

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < NUM_DUT; i++) begin
        checkOutput("busy",     i, 32'(busyA[i]), 32'(mRun[i]));
        checkOutput("done",     i, 32'(doneA[i]), 32'(mDone[i]));
        checkOutput("vec_o",    i, 32'(vecA[i]),  32'(expVec(mRun[i], mK[i], setA[i], mVecHeld[i])));
        checkOutput("sig",      i, 32'(sigA[i]),  32'(mSig[i]));
        checkOutput("pass",     i, 32'(passA[i]), 32'(mPass[i]));
        checkOutput("fail_idx", i, 32'(fIdxA[i]), 32'(expIdx(mSig[i], mMask[i])));
        checkOutput("fail_cnt", i, 32'(fCntA[i]), 32'(expCnt(mSig[i], mMask[i])));
        if (doneA[i]) begin
          lastBusy[i] = busyRun[i];
          doneCnt[i]++;
        end
        if (busyA[i]) busyRun[i]++;
        else          busyRun[i] = 0;
      end
    end
  end

  // Waits for the slowest controller (SETTLE = 3) to pulse done.
  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (doneA[1]) seen = 1'b1;
    end
    @(negedge clk);
    checkOutput("sweepDone", 1, 32'(seen), 32'd1);
  endtask

  task automatic waitVec(input logic [3:0] target, input int budget);
    for (int n = 0; n < budget && vecA[0] != target; n++) begin
      @(negedge clk);
    end
    checkOutput("reachVec", 0, 32'(vecA[0]), 32'(target));
  endtask

  task automatic runSweep();
    applyStimulus(1'b1, 1'b0);
    waitDone(200);
  endtask

  int savedDone[NUM_DUT];

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rstBusy",    0, 32'(busyA[0]), 32'd0);
    checkOutput("rstDone",    0, 32'(doneA[0]), 32'd0);
    checkOutput("rstVec",     0, 32'(vecA[0]),  32'd0);
    checkOutput("rstSig",     0, 32'(sigA[0]),  32'd0);
    checkOutput("rstPass",    0, 32'(passA[0]), 32'd0);
    checkOutput("rstFailIdx", 0, 32'(fIdxA[0]), 32'd0);
    checkOutput("rstFailCnt", 0, 32'(fCntA[0]), 32'd0);
    rst     = 1'b0;
    checkEn = 1'b1;
    @(negedge clk);

    // Correct block connected
    mode = 2'd0;
    runSweep();
    checkOutput("okSig",     0, 32'(sigA[0]),  32'h1894);
    checkOutput("okPass",    0, 32'(passA[0]), 32'd1);
    checkOutput("okFailCnt", 0, 32'(fCntA[0]), 32'd0);
    checkOutput("okFailIdx", 0, 32'(fIdxA[0]), 32'd0);
    checkOutput("busyLenS1", 0, 32'(lastBusy[0]), 32'd32);
    checkOutput("busyLenS3", 1, 32'(lastBusy[1]), 32'd64);
    checkOutput("busyLenS0", 2, 32'(lastBusy[2]), 32'd16);
    checkOutput("sigS3",     1, 32'(sigA[1]),  32'h1894);
    checkOutput("sigS0",     2, 32'(sigA[2]),  32'h1894);
    for (int i = 0; i < NUM_DUT; i++) checkOutput("doneCount", i, 32'(doneCnt[i]), 32'd1);

    // r_i tied low
    mode = 2'd1;
    runSweep();
    checkOutput("lowSig",     0, 32'(sigA[0]),  32'h0000);
    checkOutput("lowPass",    0, 32'(passA[0]), 32'd0);
    checkOutput("lowFailCnt", 0, 32'(fCntA[0]), 32'd5);
    checkOutput("lowFailIdx", 0, 32'(fIdxA[0]), 32'd2);

    // r_i tied high: all 11 zero-expected vectors mismatch, fail_cnt 11
    mode = 2'd2;
    runSweep();
    checkOutput("highSig",     0, 32'(sigA[0]),  32'hFFFF);
    checkOutput("highPass",    0, 32'(passA[0]), 32'd0);
    checkOutput("highFailCnt", 0, 32'(fCntA[0]), 32'd11);
    checkOutput("highFailIdx", 0, 32'(fIdxA[0]), 32'd0);

    // Start held high for part of a sweep: exactly one done per controller,
    // and the previous all-ones results are replaced.
    mode = 2'd0;
    for (int i = 0; i < NUM_DUT; i++) savedDone[i] = doneCnt[i];
    start = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    waitDone(200);
    for (int i = 0; i < NUM_DUT; i++) checkOutput("heldStartDone", i, 32'(doneCnt[i]), 32'(savedDone[i] + 1));
    checkOutput("rerunSig",  0, 32'(sigA[0]),  32'h1894);
    checkOutput("rerunPass", 0, 32'(passA[0]), 32'd1);

    // Abort while vector 7 is on the bus
    mode = 2'd3;
    tbl  = 16'($urandom);
    savedDone[0] = doneCnt[0];
    applyStimulus(1'b1, 1'b0);
    waitVec(4'd7, 100);
    applyStimulus(1'b0, 1'b1);
    checkOutput("abortBusy", 0, 32'(busyA[0]), 32'd0);
    checkOutput("abortVec",  0, 32'(vecA[0]),  32'd0);
    checkOutput("abortDone", 0, 32'(doneA[0]), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("abortNoDone", 0, 32'(doneCnt[0]), 32'(savedDone[0]));

    // Random traffic: starts, aborts and source changes at any time
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 29) == 0) begin
        mode = 2'($urandom_range(0, 3));
        tbl  = 16'($urandom);
      end
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (80) @(negedge clk);

    // Reset in the middle of a sweep, then a clean rerun
    mode = 2'd0;
    applyStimulus(1'b1, 1'b0);
    waitVec(4'd9, 100);
    #2 rst = 1'b1;
    #1;
    checkOutput("midRstBusy",    0, 32'(busyA[0]), 32'd0);
    checkOutput("midRstVec",     0, 32'(vecA[0]),  32'd0);
    checkOutput("midRstSig",     0, 32'(sigA[0]),  32'd0);
    checkOutput("midRstFailCnt", 0, 32'(fCntA[0]), 32'd0);
    checkOutput("midRstBusyS3",  1, 32'(busyA[1]), 32'd0);
    checkOutput("midRstVecS3",   1, 32'(vecA[1]),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runSweep();
    checkOutput("postRstSig",  0, 32'(sigA[0]),  32'h1894);
    checkOutput("postRstPass", 0, 32'(passA[0]), 32'd1);
    checkOutput("postRstBusy", 0, 32'(lastBusy[0]), 32'd32);

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
